id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU in the MIPS datapath.
- Registers decoded control and operands every cycle and drives the ALU's opcode, a and b inputs.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, requests a stall from decode and inserts a bubble. Also supports flush on taken branch.

Parameters:
DATA_W, 32, operand/result width (matches ALU a, b, result)
OP_W, 4, ALU opcode width
REG_AW, 5, register index width (32 GPRs, r0 hardwired zero)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_opcode  in  OP_W  decoded ALU opcode
id_rs_data  in  DATA_W  register-file read port A
id_rt_data  in  DATA_W  register-file read port B
id_imm  in  DATA_W  sign/zero-extended immediate
id_rs, id_rt, id_rd  in  REG_AW  source/dest indices
id_alu_src  in  1  1 = b from immediate
id_reg_write, id_mem_read, id_mem_write  in  1  control bits
flush  in  1  taken branch/jump: squash the instruction entering EX
exm_reg_write  in  1  EX/MEM writes a register
exm_rd  in  REG_AW  EX/MEM destination
exm_result  in  DATA_W  EX/MEM ALU result
mwb_reg_write  in  1  MEM/WB writes a register
mwb_rd  in  REG_AW  MEM/WB destination
mwb_data  in  DATA_W  MEM/WB writeback data
stall  out  1  hold PC and IF/ID (combinational)
alu_opcode  out  OP_W  to ALU opcode
alu_a, alu_b  out  DATA_W  to ALU operands
ex_rd  out  REG_AW  destination carried forward
ex_store_data  out  DATA_W  forwarded rt value for stores
ex_reg_write, ex_mem_read, ex_mem_write  out  1  control carried forward

Behaviour:
- Reset (async, rst_n low):
  - All registered fields clear to 0.
  - Outputs then read: alu_opcode=0, alu_a=0, alu_b=0, ex_rd=0, ex_store_data=0, ex_* controls=0.
  - stall=0.
  - Reset asserted mid-operation discards the in-flight instruction immediately. No partial state survives.
- Load-use hazard, combinational:
  - stall = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs) | (ex_rd==id_rt & ~id_alu_src | ex_rd==id_rt & id_mem_write)).
- Register update, each rising edge:
  - If flush | stall: load a bubble (opcode 0, all controls 0, rd 0, data 0).
  - Else: capture all id_* fields.
  - flush and stall together yield one bubble. Decode holds because of stall; flush wins for the squash.
- Latency: one cycle from id_* capture to ALU inputs. Fully pipelined, one instruction per cycle when not stalled.
- Forwarding (combinational on the registered rs/rt):
  - fwdA = exm_result if exm_reg_write & exm_rd!=0 & exm_rd==rs_q.
  - Else mwb_data if mwb_reg_write & mwb_rd!=0 & mwb_rd==rs_q.
  - Else rs_data_q. EX/MEM has priority over MEM/WB when both match.
  - fwdB: same rule on rt_q.
  - r0 is never forwarded.
- Operand outputs:
  - alu_a = fwdA.
  - alu_b = imm_q if alu_src_q else fwdB.
  - ex_store_data = fwdB always.
- Register-file write-then-read in the same cycle is handled by the register file, not here.
- Bubble behaviour: a bubble has reg_write=0, so it never forwards or triggers a hazard.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding paths as above; stall only on load-use.
- Undefined:
  - No forwarding muxes. alu_a = rs_data_q; alu_b = imm_q or rt_data_q; ex_store_data = rt_data_q.
  - stall also asserts on any RAW against EX (ex_reg_write & ex_rd matches id_rs, or id_rt when used) or against EX/MEM (exm_reg_write & exm_rd matches).
  - r0 is excluded in both cases.

Decomposition:
- Shared package mips_pkg:
  - DATA_W, REG_AW, OP_W.
  - ALU opcode constants (ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, NOR, codes 0-8).
  - Forward-select encoding (FWD_REG=0, FWD_EXM=1, FWD_MWB=2).
- One sub-module: fwd_unit. Combinational select generation for A and B plus the load-use detector, instantiated once.

Test Plan:
- Reset: pulse rst_n low mid-stream with a valid instruction latched -> all outputs 0 asynchronously, stall=0.
- EX/MEM forward: rs_q=3, exm_reg_write=1, exm_rd=3, exm_result=0x0000_00AA, id_rs_data stale 0x11 -> alu_a=0xAA. Also set mwb_rd=3, mwb_data=0xBB -> alu_a still 0xAA.
- r0 guard: rs_q=0, exm_rd=0, exm_reg_write=1, exm_result=0xFFFF_FFFF -> alu_a=0.
- Load-use: EX holds lw with rd=5; decode presents add with rs=5 -> stall=1 for exactly one cycle, next EX has opcode 0 and reg_write 0. After that, add proceeds with its rs operand forwarded from MEM/WB.
- Immediate: alu_src=1, imm=11, rs_data=101010101, opcode 2 -> alu_a=101010101, alu_b=11, alu_opcode=2 one cycle later.
- Flush+stall coincident -> one bubble inserted. Next cycle (stall released) captures the instruction presented by decode.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, ALU opcode codes and forward-select encoding for the MIPS datapath
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int REG_AW = 5;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_NOR = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_sel_e;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: operand forward selects and decode stall detection; ID_EX_FORWARD_EN enables forwarding
module fwd_unit #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_q,
  input  logic [REG_AW-1:0] rt_q,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_alu_src,
  input  logic              id_mem_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  output mips_pkg::fwd_sel_e sel_a,
  output mips_pkg::fwd_sel_e sel_b,
  output logic              stall
);
  import mips_pkg::*;

  function automatic logic hit(logic we, logic [REG_AW-1:0] rd, logic [REG_AW-1:0] src);
    return we & (rd != '0) & (rd == src);
  endfunction

  logic rt_used, load_use;

  // rt is a real source for register-register ops and for store data
  assign rt_used  = ~id_alu_src | id_mem_write;
  assign load_use = hit(ex_mem_read, ex_rd, id_rs) | (hit(ex_mem_read, ex_rd, id_rt) & rt_used);

`ifdef ID_EX_FORWARD_EN
  logic unused_fwd;

  assign unused_fwd = ex_reg_write;
  assign sel_a = hit(exm_reg_write, exm_rd, rs_q) ? FWD_EXM :
                 hit(mwb_reg_write, mwb_rd, rs_q) ? FWD_MWB : FWD_REG;
  assign sel_b = hit(exm_reg_write, exm_rd, rt_q) ? FWD_EXM :
                 hit(mwb_reg_write, mwb_rd, rt_q) ? FWD_MWB : FWD_REG;
  assign stall = load_use;
`else
  logic unused_fwd;

  assign unused_fwd = ^{rs_q, rt_q, mwb_reg_write, mwb_rd};
  assign sel_a = FWD_REG;
  assign sel_b = FWD_REG;
  assign stall = load_use
               | hit(ex_reg_write, ex_rd, id_rs)   | (hit(ex_reg_write, ex_rd, id_rt) & rt_used)
               | hit(exm_reg_write, exm_rd, id_rs) | (hit(exm_reg_write, exm_rd, id_rt) & rt_used);
`endif
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with hazard stall, bubble/flush and operand forwarding (ID_EX_FORWARD_EN)
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_data,
  output logic              stall,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);
  import mips_pkg::*;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_t;

  ex_t               q, d;
  fwd_sel_e          sel_a, sel_b;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd (
    .rs_q          (q.rs),
    .rt_q          (q.rt),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_alu_src    (id_alu_src),
    .id_mem_write  (id_mem_write),
    .ex_rd         (q.rd),
    .ex_reg_write  (q.reg_write),
    .ex_mem_read   (q.mem_read),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .sel_a         (sel_a),
    .sel_b         (sel_b),
    .stall         (stall)
  );

  // A flush or stall turns the incoming slot into an all-zero bubble
  assign d = (flush | stall) ? '0 :
             ex_t'{id_opcode, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
                   id_alu_src, id_reg_write, id_mem_read, id_mem_write};

  // ID/EX register; reset discards the in-flight instruction immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else        q <= d;

  assign fwd_a = (sel_a == FWD_EXM) ? exm_result : (sel_a == FWD_MWB) ? mwb_data : q.rs_data;
  assign fwd_b = (sel_b == FWD_EXM) ? exm_result : (sel_b == FWD_MWB) ? mwb_data : q.rt_data;

  assign alu_opcode    = q.opcode;
  assign alu_a         = fwd_a;
  assign alu_b         = q.alu_src ? q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_rd         = q.rd;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage in either ID_EX_FORWARD_EN build
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  id_opcode;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, flush;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_data;
  logic        stall;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  int          checks = 0;
  int          errors = 0;
`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .flush(flush), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .stall(stall), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .ex_rd(ex_rd),
    .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic id_in(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src, input logic rw,
                       input logic mr, input logic mw);
    id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = a; id_rt_data = b; id_imm = imm;
    id_alu_src = src; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_exm(input logic we, input logic [4:0] rd, input logic [31:0] v);
    exm_reg_write = we; exm_rd = rd; exm_result = v;
  endtask

  task automatic set_mwb(input logic we, input logic [4:0] rd, input logic [31:0] v);
    mwb_reg_write = we; mwb_rd = rd; mwb_data = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    flush = 1'b0;
    set_exm(0, 0, 0);
    set_mwb(0, 0, 0);
    id_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_op", 32'(alu_opcode), 0);
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    check("rst_stall", 32'(stall), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    id_in(4'd2, 5'd1, 5'd2, 5'd3, 32'd101010101, 32'h22, 32'd11, 1, 1, 0, 0);
    tick;
    check("imm_op", 32'(alu_opcode), 2);
    check("imm_a", alu_a, 32'd101010101);
    check("imm_b", alu_b, 32'd11);
    check("imm_rd", 32'(ex_rd), 3);
    check("imm_store", ex_store_data, 32'h22);
    check("imm_rw", 32'(ex_reg_write), 1);

    id_in(4'd1, 5'd4, 5'd8, 5'd9, 32'h11, 32'h44, 32'h99, 0, 0, 0, 1);
    tick;
    check("rr_b", alu_b, 32'h44);
    check("rr_mw", 32'(ex_mem_write), 1);
    check("rr_store", ex_store_data, 32'h44);
    set_exm(1, 5'd4, 32'hAA);
    set_mwb(1, 5'd4, 32'hBB);
    #1;
    check("fwd_exm_a", alu_a, FWD ? 32'hAA : 32'h11);
    check("fwd_noB", ex_store_data, 32'h44);
    set_exm(1, 5'd8, 32'hAA);
    #1;
    check("fwd_exm_b", alu_b, FWD ? 32'hAA : 32'h44);
    check("fwd_mwb_a", alu_a, FWD ? 32'hBB : 32'h11);
    set_exm(0, 0, 0);
    set_mwb(0, 0, 0);

    id_in(4'd0, 5'd0, 5'd0, 5'd10, 0, 0, 0, 0, 0, 0, 0);
    tick;
    set_exm(1, 5'd0, 32'hFFFF_FFFF);
    set_mwb(1, 5'd0, 32'hFFFF_FFFF);
    #1;
    check("r0_a", alu_a, 0);
    check("r0_b", alu_b, 0);
    set_mwb(0, 0, 0);
    set_exm(1, 5'd7, 32'h70);
    id_in(4'd0, 5'd7, 5'd1, 5'd11, 0, 0, 0, 0, 1, 0, 0);
    #1;
    check("raw_exm_stall", 32'(stall), FWD ? 0 : 1);
    id_in(4'd0, 5'd1, 5'd7, 5'd11, 0, 0, 32'd4, 1, 1, 0, 0);
    #1;
    check("rt_unused_stall", 32'(stall), 0);
    set_exm(0, 0, 0);

    id_in(4'd0, 5'd1, 5'd5, 5'd5, 32'h1000, 0, 32'd4, 1, 1, 1, 0);
    tick;
    id_in(4'd0, 5'd5, 5'd2, 5'd6, 32'h33, 32'h2, 0, 0, 1, 0, 0);
    #1;
    check("lu_stall", 32'(stall), 1);
    tick;
    check("lu_bub_op", 32'(alu_opcode), 0);
    check("lu_bub_rw", 32'(ex_reg_write), 0);
    check("lu_bub_mr", 32'(ex_mem_read), 0);
    check("lu_bub_rd", 32'(ex_rd), 0);
    set_exm(1, 5'd5, 32'h1004);
    #1;
    check("lu_stall2", 32'(stall), FWD ? 0 : 1);
`ifdef ID_EX_FORWARD_EN
    tick;
    set_exm(0, 0, 0);
    set_mwb(1, 5'd5, 32'h55);
`else
    tick;
    check("lu_bub2_rw", 32'(ex_reg_write), 0);
    set_exm(0, 0, 0);
    set_mwb(1, 5'd5, 32'h55);
    #1;
    check("lu_release", 32'(stall), 0);
    tick;
`endif
    #1;
    check("lu_a", alu_a, FWD ? 32'h55 : 32'h33);
    check("lu_b", alu_b, 32'h2);
    check("lu_rd", 32'(ex_rd), 6);
    set_mwb(0, 0, 0);

    id_in(4'd0, 5'd1, 5'd0, 5'd6, 32'h2000, 0, 32'd8, 1, 1, 1, 0);
    tick;
    id_in(4'd3, 5'd6, 5'd0, 5'd7, 32'h77, 0, 32'h3, 1, 1, 0, 0);
    flush = 1'b1;
    #1;
    check("fs_stall", 32'(stall), 1);
    tick;
    flush = 1'b0;
    check("fs_op", 32'(alu_opcode), 0);
    check("fs_rw", 32'(ex_reg_write), 0);
    check("fs_rd", 32'(ex_rd), 0);
    check("fs_release", 32'(stall), 0);
    tick;
    check("fs_cap_op", 32'(alu_opcode), 3);
    check("fs_cap_a", alu_a, 32'h77);
    check("fs_cap_rd", 32'(ex_rd), 7);

    id_in(4'd4, 5'd2, 5'd3, 5'd8, 32'h5, 32'h6, 0, 0, 1, 0, 1);
    flush = 1'b1;
    #1;
    check("fl_stall", 32'(stall), 0);
    tick;
    flush = 1'b0;
    check("fl_op", 32'(alu_opcode), 0);
    check("fl_mw", 32'(ex_mem_write), 0);
    check("fl_a", alu_a, 0);

    id_in(4'd5, 5'd2, 5'd3, 5'd9, 32'h1234, 32'h5678, 32'h10, 1, 1, 1, 0);
    tick;
    check("pre_a", alu_a, 32'h1234);
    id_in(4'd0, 5'd9, 5'd1, 5'd12, 0, 0, 0, 0, 1, 0, 0);
    #1;
    check("pre_stall", 32'(stall), 1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_op", 32'(alu_opcode), 0);
    check("ar_a", alu_a, 0);
    check("ar_b", alu_b, 0);
    check("ar_rd", 32'(ex_rd), 0);
    check("ar_store", ex_store_data, 0);
    check("ar_mr", 32'(ex_mem_read), 0);
    check("ar_rw", 32'(ex_reg_write), 0);
    check("ar_stall", 32'(stall), 0);
    tick;
    rst_n = 1'b1;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
